// File: rtl/funky_v1_cell.sv
// rtl/funky_v1_cell.sv - two-input truth-table logic cell with input sync stages and stability filter
// c follows TRUTH_TABLE[{a,b}] only after STABLE_CYCLES consecutive disagreeing edges.
module funky_v1_cell #(
    parameter logic [3:0] TRUTH_TABLE   = 4'b1000,
    parameter int         SYNC_STAGES   = 0,
    parameter int         STABLE_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    input  logic b,
    output logic c,
    output logic c_chg
);

    if (SYNC_STAGES < 0 || SYNC_STAGES > 3) begin : g_bad_sync
        $fatal(1, "funky_v1_cell: SYNC_STAGES must be 0..3");
    end
    if (STABLE_CYCLES < 1 || STABLE_CYCLES > 255) begin : g_bad_stable
        $fatal(1, "funky_v1_cell: STABLE_CYCLES must be 1..255");
    end

    localparam logic [7:0] CNT_LIMIT = 8'(STABLE_CYCLES - 1);

    logic a_s;
    logic b_s;

    if (SYNC_STAGES == 0) begin : g_no_sync
        assign a_s = a;
        assign b_s = b;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] a_stage_q;
        logic [SYNC_STAGES-1:0] b_stage_q;

        always_ff @(posedge clk) begin
            if (rst) begin
                a_stage_q <= '0;
                b_stage_q <= '0;
            end else begin
                a_stage_q[0] <= a;
                b_stage_q[0] <= b;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    a_stage_q[i] <= a_stage_q[i-1];
                    b_stage_q[i] <= b_stage_q[i-1];
                end
            end
        end

        assign a_s = a_stage_q[SYNC_STAGES-1];
        assign b_s = b_stage_q[SYNC_STAGES-1];
    end

    logic       f;
    logic       c_q;
    logic       c_d;
    logic       chg_q;
    logic       chg_d;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign f = TRUTH_TABLE[{a_s, b_s}];

    // Any edge of agreement clears the count, so only an unbroken run of disagreement commits.
    always_comb begin
        c_d   = c_q;
        cnt_d = cnt_q;
        chg_d = 1'b0;
        if (f == c_q) begin
            cnt_d = 8'd0;
        end else if (cnt_q == CNT_LIMIT) begin
            c_d   = f;
            cnt_d = 8'd0;
            chg_d = 1'b1;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q   <= 1'b0;
            chg_q <= 1'b0;
            cnt_q <= 8'd0;
        end else begin
            c_q   <= c_d;
            chg_q <= chg_d;
            cnt_q <= cnt_d;
        end
    end

    assign c     = c_q;
    assign c_chg = chg_q;

endmodule

// File: tb/tb_funky_v1_cell.sv
// tb/tb_funky_v1_cell.sv - directed checks of funky_v1_cell across several parameter sets
// Instances: 0 AND, 1 XOR, 2 NOR, 3 AND/filter3, 4 AND/sync2, 5 AND/filter4.
module tb_funky_v1_cell;

    logic       clk = 1'b0;
    logic [5:0] rst_v;
    logic [5:0] a_v;
    logic [5:0] b_v;
    logic [5:0] c_v;
    logic [5:0] chg_v;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    funky_v1_cell u_and (
        .clk(clk), .rst(rst_v[0]), .a(a_v[0]), .b(b_v[0]), .c(c_v[0]), .c_chg(chg_v[0])
    );
    funky_v1_cell #(.TRUTH_TABLE(4'b0110)) u_xor (
        .clk(clk), .rst(rst_v[1]), .a(a_v[1]), .b(b_v[1]), .c(c_v[1]), .c_chg(chg_v[1])
    );
    funky_v1_cell #(.TRUTH_TABLE(4'b0001)) u_nor (
        .clk(clk), .rst(rst_v[2]), .a(a_v[2]), .b(b_v[2]), .c(c_v[2]), .c_chg(chg_v[2])
    );
    funky_v1_cell #(.STABLE_CYCLES(3)) u_flt3 (
        .clk(clk), .rst(rst_v[3]), .a(a_v[3]), .b(b_v[3]), .c(c_v[3]), .c_chg(chg_v[3])
    );
    funky_v1_cell #(.SYNC_STAGES(2)) u_sync2 (
        .clk(clk), .rst(rst_v[4]), .a(a_v[4]), .b(b_v[4]), .c(c_v[4]), .c_chg(chg_v[4])
    );
    funky_v1_cell #(.STABLE_CYCLES(4)) u_flt4 (
        .clk(clk), .rst(rst_v[5]), .a(a_v[5]), .b(b_v[5]), .c(c_v[5]), .c_chg(chg_v[5])
    );

    task automatic check(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ab(input int idx, input logic av, input logic bv);
        a_v[idx] = av;
        b_v[idx] = bv;
    endtask

    // Apply ab to instance idx, clock once, then check c and c_chg.
    task automatic step(input int idx, input logic av, input logic bv,
                        input logic exp_c, input logic exp_chg, input string tag);
        set_ab(idx, av, bv);
        tick();
        check({tag, ".c"}, c_v[idx], exp_c);
        check({tag, ".chg"}, chg_v[idx], exp_chg);
    endtask

    initial begin
        rst_v = '1;
        a_v   = '0;
        b_v   = '0;
        tick();
        check("rst_and.c", c_v[0], 1'b0);
        check("rst_and.chg", chg_v[0], 1'b0);
        check("rst_nor.c", c_v[2], 1'b0);
        check("rst_nor.chg", chg_v[2], 1'b0);

        rst_v = '0;
        tick();
        check("nor_after_rst.c", c_v[2], 1'b1);
        check("nor_after_rst.chg", chg_v[2], 1'b1);
        check("and_idle.c", c_v[0], 1'b0);
        tick();
        check("nor_hold.c", c_v[2], 1'b1);
        check("nor_hold.chg", chg_v[2], 1'b0);

        // Default AND, one-edge latency, single pulse
        step(0, 1'b1, 1'b0, 1'b0, 1'b0, "and_10");
        step(0, 1'b1, 1'b1, 1'b1, 1'b1, "and_11");
        step(0, 1'b1, 1'b1, 1'b1, 1'b0, "and_11_hold");
        rst_v[0] = 1'b1;
        tick();
        check("and_midrst.c", c_v[0], 1'b0);
        check("and_midrst.chg", chg_v[0], 1'b0);
        rst_v[0] = 1'b0;
        tick();
        check("and_post_rst.c", c_v[0], 1'b1);
        check("and_post_rst.chg", chg_v[0], 1'b1);

        // XOR full table, then back-to-back toggles
        step(1, 1'b0, 1'b0, 1'b0, 1'b0, "xor_00");
        step(1, 1'b0, 1'b1, 1'b1, 1'b1, "xor_01");
        step(1, 1'b1, 1'b0, 1'b1, 1'b0, "xor_10");
        step(1, 1'b1, 1'b1, 1'b0, 1'b1, "xor_11");
        step(1, 1'b0, 1'b1, 1'b1, 1'b1, "xor_b2b_1");
        step(1, 1'b0, 1'b0, 1'b0, 1'b1, "xor_b2b_0");

        // Filter of 3: a 2-cycle glitch is rejected, a 3-cycle run commits
        step(3, 1'b1, 1'b1, 1'b0, 1'b0, "flt3_g1");
        step(3, 1'b1, 1'b1, 1'b0, 1'b0, "flt3_g2");
        step(3, 1'b0, 1'b0, 1'b0, 1'b0, "flt3_g3");
        step(3, 1'b0, 1'b0, 1'b0, 1'b0, "flt3_g4");
        step(3, 1'b1, 1'b1, 1'b0, 1'b0, "flt3_r1");
        step(3, 1'b1, 1'b1, 1'b0, 1'b0, "flt3_r2");
        step(3, 1'b1, 1'b1, 1'b1, 1'b1, "flt3_r3");
        step(3, 1'b1, 1'b1, 1'b1, 1'b0, "flt3_r4");

        // Two sync stages plus one filter edge: three edges of latency
        step(4, 1'b1, 1'b1, 1'b0, 1'b0, "sync_e1");
        step(4, 1'b1, 1'b1, 1'b0, 1'b0, "sync_e2");
        step(4, 1'b1, 1'b1, 1'b1, 1'b1, "sync_e3");

        // Filter of 4 with reset after two disagreeing edges
        step(5, 1'b1, 1'b1, 1'b0, 1'b0, "flt4_p1");
        step(5, 1'b1, 1'b1, 1'b0, 1'b0, "flt4_p2");
        rst_v[5] = 1'b1;
        tick();
        check("flt4_rst.c", c_v[5], 1'b0);
        check("flt4_rst.chg", chg_v[5], 1'b0);
        rst_v[5] = 1'b0;
        step(5, 1'b1, 1'b1, 1'b0, 1'b0, "flt4_q1");
        step(5, 1'b1, 1'b1, 1'b0, 1'b0, "flt4_q2");
        step(5, 1'b1, 1'b1, 1'b0, 1'b0, "flt4_q3");
        step(5, 1'b1, 1'b1, 1'b1, 1'b1, "flt4_q4");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
